// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - BIOS boot sequencer: register-file clear, BIOS word load into
// instruction memory, then two-phase instruction fetch with halt support.
module boot_sequencer #(
  parameter int MAX_WORDS    = 256,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        bios_valid,
  input  logic [31:0] bios_data,
  input  logic        bios_last,
  output logic        bios_ready,
  input  logic [31:0] pc_in,
  input  logic        halt,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_cs_n,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        on_bios,
  output logic        reg_file_reset,
  output logic        enable_pc,
  output logic [31:0] word_count,
  output logic        error
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, HALTED, ERROR} stateType;

  stateType      state, stateNext;
  logic [CW-1:0] clearCount, clearCountNext;
  logic          loadDone, loadDoneNext;
  logic          phaseB, phaseBNext;
  logic          biosReadyNext, memCsNNext, memWeNext, memOeNext;
  logic          onBiosNext, regFileResetNext, enablePcNext, errorNext;
  logic [31:0]   memAddressNext, memDataNext, wordCountNext;
  logic          accept;

  assign accept = bios_valid && bios_ready;

  always_comb begin
    stateNext        = state;
    clearCountNext   = clearCount;
    loadDoneNext     = loadDone;
    phaseBNext       = phaseB;
    biosReadyNext    = bios_ready;
    memAddressNext   = mem_address;
    memDataNext      = mem_data;
    memCsNNext       = mem_cs_n;
    memWeNext        = 1'b0;
    memOeNext        = mem_oe;
    onBiosNext       = on_bios;
    regFileResetNext = reg_file_reset;
    enablePcNext     = 1'b0;
    wordCountNext    = word_count;
    errorNext        = error;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext      = CLEAR;
          clearCountNext = '0;
        end
      end
      CLEAR: begin
        if (clearCount == CW'(CLEAR_CYCLES - 1)) begin
          stateNext        = LOAD;
          regFileResetNext = 1'b0;
          biosReadyNext    = 1'b1;
          memCsNNext       = 1'b0;
          memOeNext        = 1'b0;
          loadDoneNext     = 1'b0;
        end else begin
          clearCountNext = clearCount + 1'b1;
        end
      end
      LOAD: begin
        // loadDone marks the cycle carrying the final write; RUN follows it.
        if (loadDone) begin
          stateNext  = RUN;
          onBiosNext = 1'b0;
          memOeNext  = 1'b1;
          memCsNNext = 1'b0;
          phaseBNext = 1'b0;
        end else if (accept) begin
          memWeNext      = 1'b1;
          memAddressNext = word_count;
          memDataNext    = bios_data;
          if (word_count != 32'(MAX_WORDS))
            wordCountNext = word_count + 32'd1;
          if (bios_last) begin
            biosReadyNext = 1'b0;
            loadDoneNext  = 1'b1;
          end else if (word_count == 32'(MAX_WORDS - 1)) begin
            biosReadyNext = 1'b0;
            errorNext     = 1'b1;
            stateNext     = ERROR;
          end
        end
      end
      RUN: begin
        if (halt) begin
          stateNext = HALTED;
        end else if (!phaseB) begin
          memAddressNext = pc_in;
          enablePcNext   = 1'b1;
          phaseBNext     = 1'b1;
        end else begin
          phaseBNext = 1'b0;
        end
      end
      HALTED: begin
        if (!halt) begin
          stateNext  = RUN;
          phaseBNext = 1'b0;
        end
      end
      ERROR: begin
        // Entered with the overflowing write still on the bus; quiesce afterwards.
        memCsNNext    = 1'b1;
        memOeNext     = 1'b0;
        onBiosNext    = 1'b1;
        biosReadyNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      clearCount     <= '0;
      loadDone       <= 1'b0;
      phaseB         <= 1'b0;
      bios_ready     <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
      mem_cs_n       <= 1'b1;
      mem_we         <= 1'b0;
      mem_oe         <= 1'b0;
      on_bios        <= 1'b1;
      reg_file_reset <= 1'b1;
      enable_pc      <= 1'b0;
      word_count     <= '0;
      error          <= 1'b0;
    end else begin
      state          <= stateNext;
      clearCount     <= clearCountNext;
      loadDone       <= loadDoneNext;
      phaseB         <= phaseBNext;
      bios_ready     <= biosReadyNext;
      mem_address    <= memAddressNext;
      mem_data       <= memDataNext;
      mem_cs_n       <= memCsNNext;
      mem_we         <= memWeNext;
      mem_oe         <= memOeNext;
      on_bios        <= onBiosNext;
      reg_file_reset <= regFileResetNext;
      enable_pc      <= enablePcNext;
      word_count     <= wordCountNext;
      error          <= errorNext;
    end
  end

endmodule
